// File: rtl/fir4_mc_sched.sv
// fir4_mc_sched: multi-channel scheduler and serial datapath for a 4-tap signed
// averaging FIR. NCH sample streams share one accumulator. Channels are granted
// round-robin, each keeps a private 4-deep history, and one tap is added per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   per-channel sample valid (NCH)
//   in_data    per-channel signed samples, channel c at [c*w +: w]
//   in_ready   per-channel accept, one-hot or zero (combinational, IDLE only)
//   out_valid  result valid
//   out_data   signed sum of the channel's last 4 samples (w+2 bits)
//   out_chan   channel id of out_data
//   out_ready  consumer accept
//   flush      clear all channel histories (single-cycle pulse)
module fir4_mc_sched #(
    parameter int unsigned w   = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*w-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [w+1:0]     out_data,
    output logic [CW-1:0]    out_chan,
    input  logic             out_ready,
    input  logic             flush
);

    localparam int unsigned AW = w + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] grant;
    logic [CW-1:0] last_grant;
    logic [1:0]    k;
    logic [AW-1:0] acc;
    logic          flush_pend;
    logic [w-1:0]  hist [NCH][4];
    logic [w-1:0]  samp [NCH];

    logic          any_valid_c;
    logic [CW-1:0] pick_c;
    logic          flush_apply_c;
    logic          accept_c;

    // Channel base plus offset, wrapped modulo NCH.
    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH) s = s - NCH;
        return CW'(s);
    endfunction

    function automatic logic [AW-1:0] sext(input logic [w-1:0] x);
        return {{2{x[w-1]}}, x};
    endfunction

    // Unpack the flat sample bus into per-channel words.
    for (genvar c = 0; c < NCH; c++) begin : g_samp
        assign samp[c] = in_data[c*w +: w];
    end

    // Round-robin pick: nearest valid channel after last_grant.
    always_comb begin
        any_valid_c = 1'b0;
        pick_c      = last_grant;
        for (int unsigned i = 1; i <= NCH; i++) begin
            if (!any_valid_c && in_valid[wrap_idx(last_grant, i)]) begin
                any_valid_c = 1'b1;
                pick_c      = wrap_idx(last_grant, i);
            end
        end
    end

    // A flush seen in IDLE (fresh or pending) takes the cycle; no grant then.
    assign flush_apply_c = (state == IDLE) && (flush || flush_pend);
    assign accept_c      = (state == IDLE) && any_valid_c && !flush_apply_c;

    always_comb begin
        in_ready = '0;
        if (accept_c) in_ready[pick_c] = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = ACC;
            ACC:     if (k == 2'd3) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: histories, accumulator, result registers, grant tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist       <= '{default: '0};
            grant      <= '0;
            last_grant <= CW'(NCH - 1);
            k          <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_apply_c) begin
                        hist       <= '{default: '0};
                        flush_pend <= 1'b0;
                    end else if (accept_c) begin
                        hist[pick_c][0] <= samp[pick_c];
                        hist[pick_c][1] <= hist[pick_c][0];
                        hist[pick_c][2] <= hist[pick_c][1];
                        hist[pick_c][3] <= hist[pick_c][2];
                        grant           <= pick_c;
                        acc             <= '0;
                        k               <= '0;
                    end
                end
                ACC: begin
                    if (flush) flush_pend <= 1'b1;
                    acc <= acc + sext(hist[grant][k]);
                    k   <= k + 2'd1;
                    // Last tap: capture the complete sum directly into the output.
                    if (k == 2'd3) begin
                        out_valid <= 1'b1;
                        out_data  <= acc + sext(hist[grant][k]);
                        out_chan  <= grant;
                    end
                end
                OUT: begin
                    if (flush) flush_pend <= 1'b1;
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir4_mc_sched.sv
// Testbench for fir4_mc_sched (w=16, NCH=4). A per-channel history model
// predicts each sum at acceptance and pushes it to a scoreboard queue; a monitor
// pops and compares on every output handshake and checks result latency.
module tb_fir4_mc_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = W + 2;

    typedef struct {
        int            chan;
        logic [AW-1:0] data;
        int            acc_cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [AW-1:0]    out_data;
    logic [1:0]       out_chan;
    logic             out_ready;
    logic             flush;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q[$];
    int   mh[N][4];
    int   mlg;
    logic prev_ov = 1'b0;

    fir4_mc_sched #(.w(W), .NCH(N), .CW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .flush     (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: latency on rising out_valid, data/chan on handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && !prev_ov && q.size() > 0) begin
                checks++;
                if ((cyc - q[0].acc_cyc) !== 4) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, expected 4", cyc - q[0].acc_cyc);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data=%h chan=%0d, expected no output", out_data, out_chan);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_data !== e.data || out_chan !== 2'(e.chan)) begin
                        errors++;
                        $display("FAIL result: data=%h chan=%0d, expected data=%h chan=%0d",
                                 out_data, out_chan, e.data, e.chan);
                    end
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Model: shift sample into channel history and predict the sum.
    task automatic model_accept(input int c, input logic [W-1:0] d);
        int sum;
        exp_t e;
        mh[c][3] = mh[c][2];
        mh[c][2] = mh[c][1];
        mh[c][1] = mh[c][0];
        mh[c][0] = int'($signed(d));
        sum = mh[c][0] + mh[c][1] + mh[c][2] + mh[c][3];
        e.chan    = c;
        e.data    = AW'(sum);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        mlg = c;
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++)
            for (int j = 0; j < 4; j++) mh[c][j] = 0;
    endtask

    // Drive one sample on channel c; entered and left at a negedge.
    task automatic send(input int c, input logic [W-1:0] d);
        int n;
        in_valid[c]       = 1'b1;
        in_data[c*W +: W] = d;
        #1;
        n = 0;
        while (in_ready == '0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 4'(1 << c)) begin
            errors++;
            $display("FAIL grant: in_ready=%b, expected %b", in_ready, 4'(1 << c));
            in_valid[c] = 1'b0;
            @(negedge clk);
            return;
        end
        model_accept(c, d);
        @(posedge clk);
        #1;
        in_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL flush_idle_ready: in_ready=%b, expected 0000", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        model_clear();
        mlg = N - 1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h chan=%0d ready=%b, expected all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b ready=%b, expected 0 and 0000", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        for (int v = 1; v <= 5; v++) send(0, 16'(v));
        wait_drain();
    endtask

    task automatic test_extremes();
        repeat (4) send(1, 16'h8000);
        repeat (4) send(1, 16'h7FFF);
        wait_drain();
    endtask

    task automatic test_flush_idle();
        in_valid[3]       = 1'b1;
        in_data[3*W +: W] = 16'h0009;
        pulse_flush();
        in_valid[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        int g;
        for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'(c + 1);
        in_valid = '1;
        #1;
        for (int i = 0; i < 2 * N; i++) begin
            g = (mlg + 1) % N;
            n = 0;
            while (in_ready == '0 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (in_ready !== 4'(1 << g)) begin
                errors++;
                $display("FAIL rr_grant: in_ready=%b, expected %b", in_ready, 4'(1 << g));
            end
            model_accept(g, 16'(g + 1));
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(negedge clk);
        wait_drain();
    endtask

    task automatic test_hold();
        int n;
        logic [AW-1:0] d0;
        logic [1:0]    c0;
        out_ready = 1'b0;
        send(0, 16'h0011);
        in_valid[1]       = 1'b1;
        in_data[1*W +: W] = 16'h0022;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d0 = out_data;
        c0 = out_chan;
        checks++;
        if (!out_valid || q.size() == 0 || d0 !== q[0].data || c0 !== 2'(q[0].chan)) begin
            errors++;
            $display("FAIL hold_first: valid=%b data=%h chan=%0d, expected valid result of channel 0",
                     out_valid, d0, c0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== d0 || out_chan !== c0 || in_ready !== '0) begin
                errors++;
                $display("FAIL hold_stable: valid=%b data=%h chan=%0d ready=%b, expected 1 %h %0d 0000",
                         out_valid, out_data, out_chan, in_ready, d0, c0);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL hold_release_ready: in_ready=%b, expected 0000", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hold_next_grant: in_ready=%b, expected 0010", in_ready);
        end else begin
            model_accept(1, 16'h0022);
        end
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(negedge clk);
        wait_drain();
    endtask

    task automatic test_flush_acc();
        pulse_flush();
        for (int v = 1; v <= 4; v++) send(2, 16'(v));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_clear();
        @(negedge clk);
        send(2, 16'h0007);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        send(0, 16'h0003);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h chan=%0d ready=%b, expected all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        q.delete();
        model_clear();
        mlg = N - 1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(0, 16'h0005);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_flush_idle();
        test_round_robin();
        test_hold();
        test_flush_acc();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir4_mc_sched.md
Name: fir4_mc_sched

Overview:
- Multi-channel scheduler and serial datapath for the 4-tap signed averaging FIR.
- NCH independent sample streams share a single accumulator. The block arbitrates round-robin between channels, keeps a private 4-deep sample history per channel, and sequences one tap addition per cycle.
- Each result is returned with its channel id over a valid/ready handshake.
- It sits between the sample sources and the downstream consumer of the FIR sums.

Parameters:
- w, 16, operand bit width (two's complement)
- NCH, 4, number of requesting channels (2..8)
- CW, $clog2(NCH), channel-id width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  NCH  per-channel sample valid
- in_data  input  NCH*w  per-channel signed samples; channel c occupies bits [c*w +: w]
- in_ready  output  NCH  per-channel accept; one-hot or zero
- out_valid  output  1  result valid
- out_data  output  w+2  signed sum x[n]+x[n-1]+x[n-2]+x[n-3]
- out_chan  output  CW  channel id of out_data
- out_ready  input  1  consumer accept
- flush  input  1  clear all channel histories (single-cycle pulse)

Behaviour:
- Reset: one clock, clk. Asynchronous, active-low; reset=0 forces all state immediately.
  - state=IDLE, all histories=0, acc=0, tap counter=0.
  - out_valid=0, out_data=0, out_chan=0, in_ready=0.
  - last_grant=NCH-1, so channel 0 has first priority.
  - Reset mid-operation abandons the in-flight sample with no output.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - If any in_valid is high, grant g = first channel with in_valid set, searching from last_grant+1 and wrapping modulo NCH.
  - in_ready[g]=1 combinationally in that cycle only. in_ready is 0 in all other states.
  - On the edge, the new sample enters hist[g][0], older entries shift (hist[g][3] is dropped), acc clears, k=0, state goes to ACC.
  - No in_valid high: remain in IDLE.
- ACC:
  - Each edge: acc += sign-extended hist[g][k], then k++.
  - After k=3 (4 edges), state goes to OUT.
- OUT:
  - out_valid=1, out_data=acc, out_chan=g.
  - These outputs are held stable while out_ready=0.
  - On the edge with out_ready=1: last_grant=g, state goes to IDLE, out_valid drops.
- Latency and throughput:
  - out_valid rises 4 clocks after the acceptance edge.
  - Minimum 6 cycles per sample (IDLE+4 ACC+OUT) with out_ready held high.
- Arithmetic:
  - All operands are sign-extended to w+2 bits.
  - The 4-term sum cannot overflow; the full value is exact, with no truncation or rounding.
- Histories are per channel: a channel's sum uses only its own last 4 accepted samples. Unwritten entries are 0.
- Flush:
  - In IDLE: clears all histories on that edge. No sample is accepted on that edge; in_ready=0 that cycle.
  - In ACC or OUT: latched as pending and applied on the first IDLE cycle, before any new grant.
  - The in-flight result completes using pre-flush history.
- Simultaneous flush and reset: reset wins.
- No channel starves: with all channels valid, grants rotate 0,1,..,NCH-1,0.
- in_data of non-granted channels is ignored. A sample is consumed only on in_valid[c]&&in_ready[c].

Test Plan:
- Reset, then channel 0 sends 1,2,3,4,5 (w=16, out_ready=1) -> out_data = 1,3,6,10,14, all with out_chan=0; out_valid rises 4 clocks after each acceptance.
- Channel 1 sends 0x8000 four times -> fourth result out_data=18'h20000 (-131072); then sends 0x7FFF four times -> final result 18'h1FFFC (131068).
- All 4 channels valid continuously, channel c sending constant c+1 -> grant order 0,1,2,3,0,...; outputs per channel 1,2,3,4 then 2,4,6,8, with correct out_chan.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid, out_data and out_chan stable; in_ready=0 throughout; next grant only after the accepting edge.
- Channel 2 history {4,3,2,1}; pulse flush during ACC -> current result 10; next sample 7 -> result 7.
- Assert reset=0 asynchronously mid-ACC (between clock edges) -> outputs clear immediately with no result emitted; after release, channel 0 sample 5 -> out_data=5.
